// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer-type and response encodings
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last owner
module rr_arbiter #(
    parameter int N = 4,
    localparam int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    output logic [MW-1:0] next,
    output logic          valid
);

    logic [MW-1:0] idx;

    // scan from farthest to nearest so the first requester after last wins; last itself is checked last
    always_comb begin
        next  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = MW'((int'(last) + k) % N);
            if (req[idx]) begin
                next  = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin multi-master AHB-Lite arbiter and bridge-side mux
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic [NUM_MASTERS-1:0]                 HBUSREQ,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] HADDR_M,
    input  logic [NUM_MASTERS-1:0][1:0]            HTRANS_M,
    input  logic [NUM_MASTERS-1:0]                 HWRITE_M,
    input  logic [NUM_MASTERS-1:0]                 HSEL_M,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] HWDATA_M,
    input  logic                                   HREADY_OUT,
    output logic [NUM_MASTERS-1:0]                 HGRANT,
    output logic [MW-1:0]                          HMASTER,
    output logic [MW-1:0]                          HMASTER_D,
    output logic                                   HSEL,
    output logic [ADDR_WIDTH-1:0]                  HADDR,
    output logic [1:0]                             HTRANS,
    output logic                                   HWRITE,
    output logic [DATA_WIDTH-1:0]                  HWDATA
);

    logic [MW-1:0] rr_next;
    logic          rr_valid;
    logic [MW-1:0] owner_nxt;
    logic          locked;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req   (HBUSREQ),
        .last  (HMASTER),
        .next  (rr_next),
        .valid (rr_valid)
    );

    // SEQ and BUSY share bit 0, which marks a burst that must not be interrupted
    always_comb begin
        locked    = HTRANS_M[HMASTER][0];
        owner_nxt = rr_valid ? rr_next : '0;
    end

    // owner registers advance only on ready edges; data owner always trails address owner
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HMASTER   <= '0;
            HMASTER_D <= '0;
            HGRANT    <= NUM_MASTERS'(1);
        end else if (HREADY_OUT) begin
            HMASTER_D <= HMASTER;
            if (!locked) begin
                HMASTER <= owner_nxt;
                HGRANT  <= NUM_MASTERS'(1) << owner_nxt;
            end
        end
    end

    // route the owner's address phase and the data owner's write data to the bridge
    always_comb begin
        HADDR  = HADDR_M[HMASTER];
        HWRITE = HWRITE_M[HMASTER];
        HTRANS = HRESETn ? HTRANS_M[HMASTER] : IDLE;
        HSEL   = HRESETn ? HSEL_M[HMASTER] : 1'b0;
        HWDATA = HWDATA_M[HMASTER_D];
    end

endmodule
